// File: rtl/hamming_secded_codec_if.sv
// Handshake/status bundle for the SECDED codec: producer/consumer side is the master, the codec is the slave.
interface hamming_secded_codec_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
);
  localparam int P  = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6;
  localparam int N  = DATA_W + P + 1;
  localparam int PW = $clog2(N);

  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [N-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic             out_mode;
  logic             err_single;
  logic             err_double;
  logic [PW-1:0]    err_pos;
  logic             clr_cnt;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  modport master (
    output in_valid, mode, in_data, out_ready, clr_cnt,
    input  in_ready, out_valid, out_data, out_mode, err_single, err_double, err_pos,
           corr_cnt, uncorr_cnt
  );

  modport slave (
    input  in_valid, mode, in_data, out_ready, clr_cnt,
    output in_ready, out_valid, out_data, out_mode, err_single, err_double, err_pos,
           corr_cnt, uncorr_cnt
  );
endinterface

// File: rtl/hamming_secded_codec.sv
// Parametrised Hamming SECDED encoder/decoder with valid/ready handshake and saturating error counters.
// Bit 0 is overall parity; bits 1..N-1 are Hamming positions, parity at powers of two.
module hamming_secded_codec #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
) (
  input logic                 clk,
  input logic                 rst,
  hamming_secded_codec_if.slave bus
);
  localparam int K  = DATA_W;
  localparam int P  = (K <= 4) ? 3 : (K <= 11) ? 4 : (K <= 26) ? 5 : 6;
  localparam int N  = K + P + 1;
  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic is_pow2(input int j);
    return (j & (j - 32'sd1)) == 32'sd0;
  endfunction

  function automatic logic [P-1:0] syndrome(input logic [N-1:0] cw);
    logic [P-1:0] s;
    s = '0;
    for (int j = 1; j < N; j++) begin
      for (int i = 0; i < P; i++) begin
        if (((j >> i) & 32'sd1) != 32'sd0) s[i] = s[i] ^ cw[j];
      end
    end
    return s;
  endfunction

  function automatic logic [K-1:0] extract_data(input logic [N-1:0] cw);
    logic [K-1:0] d;
    int           di;
    d  = '0;
    di = 0;
    for (int j = 1; j < N; j++) begin
      if (!is_pow2(j)) begin
        d[di] = cw[j];
        di    = di + 32'sd1;
      end
    end
    return d;
  endfunction

  // Parity positions start at zero, so each syndrome bit directly yields its parity value.
  function automatic logic [N-1:0] encode_cw(input logic [K-1:0] d);
    logic [N-1:0] cw;
    logic [P-1:0] s;
    int           di;
    cw = '0;
    di = 0;
    for (int j = 1; j < N; j++) begin
      if (!is_pow2(j)) begin
        cw[j] = d[di];
        di    = di + 32'sd1;
      end
    end
    s = syndrome(cw);
    for (int i = 0; i < P; i++) cw[32'sd1 << i] = s[i];
    cw[0] = ^cw;
    return cw;
  endfunction

  state_t           state_q, state_d;
  logic [N-1:0]     data_q, data_d;
  logic             mode_q, mode_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic             out_mode_q, out_mode_d;
  logic             err_single_q, err_single_d;
  logic             err_double_q, err_double_d;
  logic [PW-1:0]    err_pos_q, err_pos_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  logic [P-1:0]     syn_s;
  logic             par_s;
  logic [N-1:0]     fixed_s;
  logic             single_s;
  logic             double_s;
  logic [PW-1:0]    pos_s;
  logic             inc_corr_s;
  logic             inc_uncorr_s;

  // Syndrome classification of the latched codeword.
  always_comb begin
    syn_s    = syndrome(data_q);
    par_s    = ^data_q;
    fixed_s  = data_q;
    single_s = 1'b0;
    double_s = 1'b0;
    pos_s    = '0;
    if (par_s) begin
      if (syn_s == '0) begin
        single_s = 1'b1;
      end else if (int'(syn_s) <= N - 1) begin
        fixed_s  = data_q ^ ({{(N-1){1'b0}}, 1'b1} << syn_s);
        single_s = 1'b1;
        pos_s    = PW'(syn_s);
      end else begin
        double_s = 1'b1;
      end
    end else if (syn_s != '0) begin
      double_s = 1'b1;
    end else begin
      single_s = 1'b0;
    end
  end

  // FSM next state, result capture and counter update.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    mode_d       = mode_q;
    out_data_d   = out_data_q;
    out_mode_d   = out_mode_q;
    err_single_d = err_single_q;
    err_double_d = err_double_q;
    err_pos_d    = err_pos_q;
    inc_corr_s   = 1'b0;
    inc_uncorr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          mode_d  = bus.mode;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        state_d    = ST_HOLD;
        out_mode_d = mode_q;
        if (mode_q) begin
          out_data_d   = {{(N-K){1'b0}}, extract_data(fixed_s)};
          err_single_d = single_s;
          err_double_d = double_s;
          err_pos_d    = pos_s;
          inc_corr_s   = single_s;
          inc_uncorr_s = double_s;
        end else begin
          out_data_d   = encode_cw(data_q[K-1:0]);
          err_single_d = 1'b0;
          err_double_d = 1'b0;
          err_pos_d    = '0;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.clr_cnt) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else begin
      corr_cnt_d   = (inc_corr_s && (corr_cnt_q != {CNT_W{1'b1}})) ? corr_cnt_q + 1'b1 : corr_cnt_q;
      uncorr_cnt_d = (inc_uncorr_s && (uncorr_cnt_q != {CNT_W{1'b1}})) ? uncorr_cnt_q + 1'b1
                                                                        : uncorr_cnt_q;
    end
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      mode_q       <= 1'b0;
      out_data_q   <= '0;
      out_mode_q   <= 1'b0;
      err_single_q <= 1'b0;
      err_double_q <= 1'b0;
      err_pos_q    <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      mode_q       <= mode_d;
      out_data_q   <= out_data_d;
      out_mode_q   <= out_mode_d;
      err_single_q <= err_single_d;
      err_double_q <= err_double_d;
      err_pos_q    <= err_pos_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_HOLD);
  assign bus.out_data   = out_data_q;
  assign bus.out_mode   = out_mode_q;
  assign bus.err_single = err_single_q;
  assign bus.err_double = err_double_q;
  assign bus.err_pos    = err_pos_q;
  assign bus.corr_cnt   = corr_cnt_q;
  assign bus.uncorr_cnt = uncorr_cnt_q;
endmodule

// File: tb/tb_hamming_secded_codec.sv
// Directed scoreboard bench for the SECDED codec at DATA_W=4 (N=8) with 2-bit saturating counters.
module tb_hamming_secded_codec;
  logic clk;
  logic rst;

  hamming_secded_codec_if #(.DATA_W(4), .CNT_W(2)) bus ();

  hamming_secded_codec #(.DATA_W(4), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       m;
    logic       s;
    logic       d;
    logic [2:0] pos;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp;
  int         n_err;
  logic [1:0] m_corr;
  logic [1:0] m_uncorr;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

  // Reference (7,4)+overall-parity encoder written from the position equations.
  function automatic logic [7:0] ref_enc(input logic [3:0] d);
    logic       p1, p2, p4;
    logic [7:0] c;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    c  = {d[3], d[2], d[1], p4, d[0], p2, p1, 1'b0};
    c[0] = ^c;
    return c;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_word(input logic m, input logic [7:0] din, input logic [7:0] edata,
                          input logic es, input logic ed, input logic [2:0] epos,
                          input logic clr, input int stall);
    exp_t e;
    exp_t got;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.in_data  = din;
    wait_ready();
    @(posedge clk);
    e = '{data: edata, m: m, s: es, d: ed, pos: epos};
    sb.push_back(e);
    #1;
    bus.in_valid = 1'b0;
    bus.mode     = ~m;
    bus.in_data  = 8'h5A;
    @(negedge clk);
    check("calc_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("calc_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.clr_cnt   = clr;
    bus.out_ready = (stall == 0);
    @(posedge clk);
    if (clr) begin
      m_corr   = 2'd0;
      m_uncorr = 2'd0;
    end else begin
      if (m && es) m_corr = sat_inc(m_corr);
      if (m && ed) m_uncorr = sat_inc(m_uncorr);
    end
    #1;
    bus.clr_cnt = 1'b0;
    @(negedge clk);
    check("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
    got = sb.pop_front();
    check("out_data", {24'd0, bus.out_data}, {24'd0, got.data});
    check("out_mode", {31'd0, bus.out_mode}, {31'd0, got.m});
    check("err_single", {31'd0, bus.err_single}, {31'd0, got.s});
    check("err_double", {31'd0, bus.err_double}, {31'd0, got.d});
    check("err_pos", {29'd0, bus.err_pos}, {29'd0, got.pos});
    check("corr_cnt", {30'd0, bus.corr_cnt}, {30'd0, m_corr});
    check("uncorr_cnt", {30'd0, bus.uncorr_cnt}, {30'd0, m_uncorr});
    check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = ((i % 2) == 0);
      bus.in_data  = 8'hFF;
      @(negedge clk);
      check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_out_data", {24'd0, bus.out_data}, {24'd0, got.data});
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("post_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    logic [3:0] dv [4];
    logic [2:0] fp [4];
    logic [7:0] cw;
    n_cmp = 0;
    n_err = 0;
    m_corr = 2'd0;
    m_uncorr = 2'd0;
    clk = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.mode = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b1;
    bus.clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    check("rst_flags", {29'd0, bus.err_single, bus.err_double, bus.out_mode}, 32'd0);
    check("rst_counters", {28'd0, bus.corr_cnt, bus.uncorr_cnt}, 32'd0);
    rst = 1'b0;

    // Spec vectors: encode, clean decode, single errors at bit 5 and bit 0, double error with stall.
    run_word(1'b0, 8'hFB, 8'hAA, 1'b0, 1'b0, 3'd0, 1'b0, 0);
    run_word(1'b1, 8'hAA, 8'h0B, 1'b0, 1'b0, 3'd0, 1'b0, 0);
    run_word(1'b1, 8'h8A, 8'h0B, 1'b1, 1'b0, 3'd5, 1'b0, 0);
    run_word(1'b1, 8'hAB, 8'h0B, 1'b1, 1'b0, 3'd0, 1'b0, 0);
    run_word(1'b1, 8'hCA, 8'h0D, 1'b0, 1'b1, 3'd0, 1'b0, 5);

    // Round trips with one flipped bit each; corr_cnt saturates at 3.
    dv = '{4'h0, 4'h5, 4'hE, 4'hF};
    fp = '{3'd1, 3'd3, 3'd6, 3'd7};
    for (int k = 0; k < 4; k++) begin
      cw = ref_enc(dv[k]);
      run_word(1'b0, {4'hC, dv[k]}, cw, 1'b0, 1'b0, 3'd0, 1'b0, 0);
      run_word(1'b1, cw ^ (8'h01 << fp[k]), {4'h0, dv[k]}, 1'b1, 1'b0, fp[k], 1'b0, 0);
    end

    // Reset during CALC drops the word and clears counters.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mode = 1'b1;
    bus.in_data = 8'h8A;
    wait_ready();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_corr = 2'd0;
    m_uncorr = 2'd0;
    @(negedge clk);
    check("rstcalc_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rstcalc_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rstcalc_counters", {28'd0, bus.corr_cnt, bus.uncorr_cnt}, 32'd0);
    check("rstcalc_out_data", {24'd0, bus.out_data}, 32'd0);

    run_word(1'b1, 8'h8A, 8'h0B, 1'b1, 1'b0, 3'd5, 1'b0, 0);
    run_word(1'b1, 8'hCA, 8'h0D, 1'b0, 1'b1, 3'd0, 1'b1, 0);
    run_word(1'b1, 8'hCA, 8'h0D, 1'b0, 1'b1, 3'd0, 1'b0, 0);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
